conv2d: RTL and testbench
=========================

# conv2d

Single-channel 2-D convolution engine: convolves a full unsigned input feature map with a signed kernel, using zero padding and configurable strides. Both operands arrive as parallel array ports. The engine computes one output pixel per clock in raster order into a registered output feature map, then raises a sticky done flag. It sits behind the CNN feature-map loader, and downstream pooling or other layers consume its output.

## Interface
- IFMAP_HEIGHT, 128: input rows
- IFMAP_WIDTH, 128: input columns
- KERNEL_HEIGHT, 3: kernel rows
- KERNEL_WIDTH, 3: kernel columns
- DATA_WIDTH, 8: pixel and weight width
- H_STRIDE, 1: column step
- V_STRIDE, 1: row step
- PADDING, 1: zero border width, applied on every side
- Derived: OUT_H = (IFMAP_HEIGHT-KERNEL_HEIGHT+2*PADDING)/V_STRIDE + 1 and OUT_W = (IFMAP_WIDTH-KERNEL_WIDTH+2*PADDING)/H_STRIDE + 1 (integer division).

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- en  in  1  run enable
- ifmap  in  [IFMAP_HEIGHT][IFMAP_WIDTH] x DATA_WIDTH  unsigned input map
- weights  in  [KERNEL_HEIGHT][KERNEL_WIDTH] x DATA_WIDTH  signed kernel
- ofmap  out  [OUT_H][OUT_W] x DATA_WIDTH  unsigned result, registered
- done_conv  out  1  high once every output pixel is written

## Operation
- FSM states IDLE, RUN, DONE. Output counters row and col start at 0.
- IDLE: moves to RUN on an edge where en=1. No pixel is written on that edge.
- RUN, en=1: computes pixel (row,col) and writes it to ofmap[row][col]. col then advances; at OUT_W-1 it wraps to 0 and row increments.
- RUN, en=0: holds the state, the counters and ofmap.
- Completion: on the edge that writes (OUT_H-1, OUT_W-1), the FSM moves to DONE and done_conv is set.
- DONE: done_conv stays high and ofmap is frozen. en is ignored. Only reset leaves DONE.
- Pixel (r,c) = sum over i<KERNEL_HEIGHT, j<KERNEL_WIDTH of x(r*V_STRIDE+i-PADDING, c*H_STRIDE+j-PADDING) * weights[i][j].
- Any tap x outside the input array counts as 0.
- Arithmetic:
  - Each pixel is zero-extended to DATA_WIDTH+1 bits signed and multiplied by the signed weight.
  - Products are summed in a signed accumulator of 2*DATA_WIDTH+1+$clog2(KERNEL_HEIGHT*KERNEL_WIDTH) bits. No intermediate overflow is possible.
- Output rule: negative sums store 0 (ReLU). Sums above 2^DATA_WIDTH-1 store 2^DATA_WIDTH-1.
- ifmap and weights are read combinationally each cycle. They must stay stable from reset release until done_conv.

## Timing
- Reset state: FSM in IDLE, counters 0, every ofmap entry 0, done_conv 0.
- Reset asserted mid-run clears everything immediately (asynchronous). The run restarts from pixel (0,0) after release.
- With en held at 1, done_conv rises on rising edge number OUT_H*OUT_W+1 after en is first sampled. For the default parameters that is edge 16385.
- ofmap[r][c] is valid from the edge that wrote it onward.

## Structure
- Package conv_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - functions computing OUT_H, OUT_W and the accumulator width
- One sub-module, conv_window_mac:
  - combinational
  - takes ifmap, weights, row and col
  - performs padding-aware tap selection, KERNEL_HEIGHT*KERNEL_WIDTH multiplies, an adder tree and the ReLU/saturate stage
  - returns one DATA_WIDTH result
- The top level contains the FSM, the counters and the ofmap register array.

## Test plan
- Identity kernel (center 1, others 0), 4x4 ramp input 0..15, PADDING=1: ofmap equals ifmap and done_conv rises on edge 17.
- All-ones 3x3 kernel, 4x4 map of all 1s, PADDING=1: corner outputs 4, edge outputs 6, interior outputs 9.
- Saturation and ReLU, 4x4 input of all 255:
  - all weights 127: every output is 255
  - all weights -1: every output is 0
- KERNEL 2x2 of all 1s, 4x4 ramp, PADDING=0, both strides 2: output is 2x2 = {10,18; 42,50}, and done_conv rises on edge 5.
- en dropped for 5 cycles mid-run: counters and ofmap hold, the final results are unchanged, and done_conv is delayed by exactly 5 cycles.
- Reset pulsed mid-run: ofmap clears to 0 and done_conv drops to 0 immediately. The rerun produces the correct full result.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and elaboration-time helpers for the conv2d engine.
//   conv_state_e : engine FSM states (IDLE, RUN, DONE)
//   out_dim      : output extent along one axis (serves for OUT_H and OUT_W)
//   acc_width    : signed accumulator width that cannot overflow
//   cnt_width    : index width for an array extent (at least 1 bit)
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  function automatic int out_dim(input int in_dim, input int k_dim,
                                 input int pad, input int stride);
    return (in_dim - k_dim + 2 * pad) / stride + 1;
  endfunction

  function automatic int acc_width(input int dw, input int kh, input int kw);
    return 2 * dw + 1 + $clog2(kh * kw);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_mac.sv
// conv_window_mac: combinational evaluation of one output pixel.
//   ifmap   : unsigned input feature map
//   weights : signed kernel
//   row/col : output pixel coordinates
//   pixel   : ReLU'd and saturated result for (row, col)
// Taps that fall into the zero border contribute 0.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int IFMAP_HEIGHT  = 128,
  parameter int IFMAP_WIDTH   = 128,
  parameter int KERNEL_HEIGHT = 3,
  parameter int KERNEL_WIDTH  = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int H_STRIDE      = 1,
  parameter int V_STRIDE      = 1,
  parameter int PADDING       = 1,
  parameter int ROW_W         = 7,
  parameter int COL_W         = 7
) (
  input  logic        [DATA_WIDTH-1:0] ifmap   [IFMAP_HEIGHT][IFMAP_WIDTH],
  input  logic signed [DATA_WIDTH-1:0] weights [KERNEL_HEIGHT][KERNEL_WIDTH],
  input  logic        [ROW_W-1:0]      row,
  input  logic        [COL_W-1:0]      col,
  output logic        [DATA_WIDTH-1:0] pixel
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, KERNEL_HEIGHT, KERNEL_WIDTH);
  localparam int PROD_W = 2 * DATA_WIDTH + 1;
  localparam int Y_W    = cnt_width(IFMAP_HEIGHT);
  localparam int X_W    = cnt_width(IFMAP_WIDTH);

  logic signed [DATA_WIDTH:0] tap  [KERNEL_HEIGHT][KERNEL_WIDTH];
  logic signed [PROD_W-1:0]   prod [KERNEL_HEIGHT][KERNEL_WIDTH];
  logic signed [ACC_W-1:0]    sum;
  int                         y;
  int                         x;

  always_comb begin
    y   = 0;
    x   = 0;
    sum = '0;
    for (int unsigned i = 0; i < KERNEL_HEIGHT; i++) begin
      for (int unsigned j = 0; j < KERNEL_WIDTH; j++) begin
        // Signed input coordinates; negative or past-the-edge means border.
        y = int'(row) * V_STRIDE + int'(i) - PADDING;
        x = int'(col) * H_STRIDE + int'(j) - PADDING;
        tap[i][j] = '0;
        if (y >= 0 && y < IFMAP_HEIGHT && x >= 0 && x < IFMAP_WIDTH)
          tap[i][j] = signed'({1'b0, ifmap[Y_W'(y)][X_W'(x)]});
        prod[i][j] = PROD_W'(tap[i][j]) * PROD_W'(weights[i][j]);
        sum        = sum + ACC_W'(prod[i][j]);
      end
    end

    // Non-negative sums saturate when any bit above the pixel width is set.
    if (sum[ACC_W-1])
      pixel = '0;
    else if (|sum[ACC_W-2:DATA_WIDTH])
      pixel = '1;
    else
      pixel = sum[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/conv2d.sv
// conv2d: 2-D convolution engine, one output pixel per enabled clock in
// raster order, results held in a registered output map.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high
//   en        : run enable (start from IDLE, advance in RUN)
//   ifmap     : unsigned input map, stable from reset release until done
//   weights   : signed kernel, stable from reset release until done
//   ofmap     : registered unsigned result map
//   done_conv : sticky completion flag, cleared only by reset
module conv2d
  import conv_pkg::*;
#(
  parameter int IFMAP_HEIGHT  = 128,
  parameter int IFMAP_WIDTH   = 128,
  parameter int KERNEL_HEIGHT = 3,
  parameter int KERNEL_WIDTH  = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int H_STRIDE      = 1,
  parameter int V_STRIDE      = 1,
  parameter int PADDING       = 1,
  localparam int OUT_H = out_dim(IFMAP_HEIGHT, KERNEL_HEIGHT, PADDING, V_STRIDE),
  localparam int OUT_W = out_dim(IFMAP_WIDTH, KERNEL_WIDTH, PADDING, H_STRIDE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic        [DATA_WIDTH-1:0] ifmap   [IFMAP_HEIGHT][IFMAP_WIDTH],
  input  logic signed [DATA_WIDTH-1:0] weights [KERNEL_HEIGHT][KERNEL_WIDTH],
  output logic        [DATA_WIDTH-1:0] ofmap   [OUT_H][OUT_W],
  output logic                         done_conv
);

  localparam int ROW_W = cnt_width(OUT_H);
  localparam int COL_W = cnt_width(OUT_W);

  conv_state_e           state;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic [DATA_WIDTH-1:0] pixel;

  conv_window_mac #(
    .IFMAP_HEIGHT (IFMAP_HEIGHT),
    .IFMAP_WIDTH  (IFMAP_WIDTH),
    .KERNEL_HEIGHT(KERNEL_HEIGHT),
    .KERNEL_WIDTH (KERNEL_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .H_STRIDE     (H_STRIDE),
    .V_STRIDE     (V_STRIDE),
    .PADDING      (PADDING),
    .ROW_W        (ROW_W),
    .COL_W        (COL_W)
  ) u_mac (
    .ifmap  (ifmap),
    .weights(weights),
    .row    (row),
    .col    (col),
    .pixel  (pixel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      done_conv <= 1'b0;
      for (int unsigned r = 0; r < OUT_H; r++)
        for (int unsigned c = 0; c < OUT_W; c++)
          ofmap[r][c] <= '0;
    end else begin
      unique case (state)
        IDLE: if (en) state <= RUN;
        RUN: begin
          if (en) begin
            ofmap[row][col] <= pixel;
            if (col == COL_W'(OUT_W - 1)) begin
              col <= '0;
              if (row == ROW_W'(OUT_H - 1)) begin
                state     <= DONE;
                done_conv <= 1'b1;
              end else begin
                row <= row + ROW_W'(1);
              end
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d.sv
// tb_conv2d: scoreboard bench for conv2d. Two instances: a 4x4 map with a
// padded 3x3 kernel (stride 1) and a 4x4 map with an unpadded 2x2 kernel
// (stride 2). Expected maps and completion edges come from a direct
// arithmetic model of the convolution and are queued when a run starts;
// per-instance monitors pop and compare when done_conv rises.
module tb_conv2d;

  localparam int NA = 16;  // 4x4 output, 3x3 kernel, pad 1, stride 1
  localparam int NB = 4;   // 2x2 output, 2x2 kernel, pad 0, stride 2

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              ra, ea, done_a;
  logic        [7:0] if_a [4][4];
  logic signed [7:0] w_a  [3][3];
  logic        [7:0] of_a [4][4];

  logic              rb, eb, done_b;
  logic        [7:0] if_b [4][4];
  logic signed [7:0] w_b  [2][2];
  logic        [7:0] of_b [2][2];

  conv2d #(
    .IFMAP_HEIGHT(4), .IFMAP_WIDTH(4), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(3),
    .DATA_WIDTH(8), .H_STRIDE(1), .V_STRIDE(1), .PADDING(1)
  ) dut_a (
    .clk(clk), .reset(ra), .en(ea), .ifmap(if_a), .weights(w_a),
    .ofmap(of_a), .done_conv(done_a)
  );

  conv2d #(
    .IFMAP_HEIGHT(4), .IFMAP_WIDTH(4), .KERNEL_HEIGHT(2), .KERNEL_WIDTH(2),
    .DATA_WIDTH(8), .H_STRIDE(2), .V_STRIDE(2), .PADDING(0)
  ) dut_b (
    .clk(clk), .reset(rb), .en(eb), .ifmap(if_b), .weights(w_b),
    .ofmap(of_b), .done_conv(done_b)
  );

  int img_a [4][4];
  int ker_a [3][3];
  int img_b [4][4];
  int ker_b [3][3];

  int qa_pix[$], qa_done[$];
  int qb_pix[$], qb_done[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: direct definition of zero-padded strided convolution + clamp.
  function automatic int ref_pix(input int img[4][4], input int ker[3][3],
                                 input int kh, input int kw, input int pad,
                                 input int stride, input int r, input int c);
    int s = 0;
    for (int i = 0; i < kh; i++) begin
      for (int j = 0; j < kw; j++) begin
        int y;
        int x;
        y = r * stride + i - pad;
        x = c * stride + j - pad;
        if (y >= 0 && y < 4 && x >= 0 && x < 4) s += img[y][x] * ker[i][j];
      end
    end
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  function automatic int ref_a(input int r, input int c);
    return ref_pix(img_a, ker_a, 3, 3, 1, 1, r, c);
  endfunction

  function automatic int ref_b(input int r, input int c);
    return ref_pix(img_b, ker_b, 2, 2, 0, 2, r, c);
  endfunction

  function automatic int nz_a();
    int n = 0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) if (of_a[r][c] != 0) n++;
    return n;
  endfunction

  function automatic int nz_b();
    int n = 0;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) if (of_b[r][c] != 0) n++;
    return n;
  endfunction

  task automatic load_a();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) if_a[r][c] = 8'(img_a[r][c]);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) w_a[i][j] = 8'(ker_a[i][j]);
  endtask

  task automatic load_b();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) if_b[r][c] = 8'(img_b[r][c]);
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) w_b[i][j] = 8'(ker_b[i][j]);
  endtask

  task automatic img_a_ramp();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img_a[r][c] = r * 4 + c;
  endtask

  task automatic img_a_const(input int v);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img_a[r][c] = v;
  endtask

  task automatic ker_a_const(input int v);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) ker_a[i][j] = v;
  endtask

  task automatic ker_a_ident();
    ker_a_const(0);
    ker_a[1][1] = 1;
  endtask

  // Monitors: compare the whole map and the completion edge on done rise.
  logic done_a_q = 1'b0;
  always @(negedge clk) begin
    if (done_a && !done_a_q) begin
      if (qa_done.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected_done: done_conv rose at edge %0d, expected no completion", cyc);
      end else begin
        check("a_done_edge", cyc, qa_done.pop_front());
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            check($sformatf("a_ofmap[%0d][%0d]", r, c), int'(of_a[r][c]), qa_pix.pop_front());
      end
    end
    done_a_q = done_a;
  end

  logic done_b_q = 1'b0;
  always @(negedge clk) begin
    if (done_b && !done_b_q) begin
      if (qb_done.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected_done: done_conv rose at edge %0d, expected no completion", cyc);
      end else begin
        check("b_done_edge", cyc, qb_done.pop_front());
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            check($sformatf("b_ofmap[%0d][%0d]", r, c), int'(of_b[r][c]), qb_pix.pop_front());
      end
    end
    done_b_q = done_b;
  end

  task automatic wait_done_a(input int budget);
    int k = 0;
    while (!done_a && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done_a) begin
      n_checks++;
      $display("FAIL a_timeout: done_conv still 0 after %0d cycles, expected 1", budget);
      qa_pix.delete();
      qa_done.delete();
    end
  endtask

  task automatic wait_done_b(input int budget);
    int k = 0;
    while (!done_b && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done_b) begin
      n_checks++;
      $display("FAIL b_timeout: done_conv still 0 after %0d cycles, expected 1", budget);
      qb_pix.delete();
      qb_done.delete();
    end
  endtask

  // Full run on instance A; optionally drop en for 'gap' cycles once
  // 'gap_at' edges have passed since en was raised.
  task automatic run_a(input int gap, input int gap_at);
    @(negedge clk);
    ra = 1'b1;
    ea = 1'b0;
    load_a();
    @(negedge clk);
    check("a_reset_done", int'(done_a), 0);
    check("a_reset_ofmap_nonzero", nz_a(), 0);
    ra = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) qa_pix.push_back(ref_a(r, c));
    qa_done.push_back(cyc + 1 + NA + gap);
    ea = 1'b1;
    if (gap > 0) begin
      repeat (gap_at) @(negedge clk);
      ea = 1'b0;
      repeat (gap) @(negedge clk);
      for (int k = 0; k < NA; k++)
        check($sformatf("a_hold_pix%0d", k), int'(of_a[k / 4][k % 4]),
              (k < gap_at - 1) ? ref_a(k / 4, k % 4) : 0);
      check("a_hold_done", int'(done_a), 0);
      ea = 1'b1;
    end
    wait_done_a(NA + gap + 10);
    // DONE must ignore en and keep the map frozen.
    repeat (2) @(negedge clk);
    ea = 1'b0;
    @(negedge clk);
    ea = 1'b1;
    repeat (3) @(negedge clk);
    check("a_done_sticky", int'(done_a), 1);
    for (int k = 0; k < NA; k += 5)
      check($sformatf("a_frozen_pix%0d", k), int'(of_a[k / 4][k % 4]), ref_a(k / 4, k % 4));
    ea = 1'b0;
  endtask

  task automatic run_b();
    @(negedge clk);
    rb = 1'b1;
    eb = 1'b0;
    load_b();
    @(negedge clk);
    check("b_reset_done", int'(done_b), 0);
    check("b_reset_ofmap_nonzero", nz_b(), 0);
    rb = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) qb_pix.push_back(ref_b(r, c));
    qb_done.push_back(cyc + 1 + NB);
    eb = 1'b1;
    wait_done_b(NB + 10);
    repeat (2) @(negedge clk);
    eb = 1'b0;
  endtask

  task automatic reset_tests_a();
    int exp_nz;
    img_a_ramp();
    ker_a_ident();
    @(negedge clk);
    ra = 1'b1;
    ea = 1'b0;
    load_a();
    @(negedge clk);
    ra = 1'b0;
    @(negedge clk);
    ea = 1'b1;
    repeat (9) @(negedge clk);  // start edge + 8 written pixels
    exp_nz = 0;
    for (int k = 0; k < 8; k++) if (ref_a(k / 4, k % 4) != 0) exp_nz++;
    check("a_midrun_written", nz_a(), exp_nz);
    @(posedge clk);
    #2 ra = 1'b1;
    #1;
    check("a_async_clear_ofmap", nz_a(), 0);
    check("a_async_clear_done", int'(done_a), 0);
    @(negedge clk);
    ea = 1'b0;
    run_a(0, 0);
    @(posedge clk);
    #2 ra = 1'b1;
    #1;
    check("a_async_done_drop", int'(done_a), 0);
    check("a_async_done_ofmap", nz_a(), 0);
    @(negedge clk);
    run_a(0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    ra = 1'b1; ea = 1'b0;
    rb = 1'b1; eb = 1'b0;
    img_a_const(0); ker_a_const(0);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img_b[r][c] = 0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) ker_b[i][j] = 0;
    load_a();
    load_b();
    repeat (2) @(negedge clk);

    img_a_ramp();      ker_a_ident();    run_a(0, 0);  // identity
    img_a_const(1);    ker_a_const(1);   run_a(0, 0);  // 4 / 6 / 9
    img_a_const(255);  ker_a_const(127); run_a(0, 0);  // saturate
    img_a_const(255);  ker_a_const(-1);  run_a(0, 0);  // ReLU
    img_a_ramp();      ker_a_ident();    run_a(5, 7);  // en gap
    reset_tests_a();

    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          img_a[r][c] = (t < 2) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 255));
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          ker_a[i][j] = (t < 2) ? int'($urandom_range(0, 16)) - 8 : int'($urandom_range(0, 255)) - 128;
      run_a(0, 0);
    end

    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img_b[r][c] = r * 4 + c;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) ker_b[i][j] = 1;
    run_b();  // {10,18; 42,50}, done on edge 5

    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          img_b[r][c] = int'($urandom_range(0, 63));
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          ker_b[i][j] = int'($urandom_range(0, 10)) - 5;
      run_b();
    end

    repeat (3) @(negedge clk);
    check("a_queue_drained", qa_done.size(), 0);
    check("b_queue_drained", qb_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
